// File: rtl/conf_bus_writer.sv
// conf_bus_writer: turns a host stream of packet words (one header followed by
// N data words) into 64-bit configuration bus words. For each packet it emits
// N mem-write words, then one pc_max word, then one pc_loop word.
// Optional feature macro: CONF_WRITER_BROADCAST_EN (target 8'hFF is legal).
module conf_bus_writer #(
  parameter int unsigned NUM_TARGETS = 128,
  parameter int unsigned NUM_THREADS = 7
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_data,
  output logic [63:0] conf_bus_out,
  output logic        busy,
  output logic        err,
  output logic        pkt_done
);

  typedef enum logic [1:0] {StIdle, StData, StPcMax, StPcLoop} state_e;

  localparam logic [1:0] KindMem    = 2'b00;
  localparam logic [1:0] KindPcMax  = 2'b01;
  localparam logic [1:0] KindPcLoop = 2'b10;

  state_e      state_q, state_d;
  logic [7:0]  target_q, target_d;
  logic [2:0]  thread_q, thread_d;
  logic [7:0]  loop_pc_q, loop_pc_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [7:0]  idx_q, idx_d;
  logic        err_q, err_d;
  logic [63:0] bus_q, bus_d;
  logic        done_q, done_d;

  logic        xfer;
  logic        bad_target;
  logic        bad_hdr;

  // Header fields straight off the input word
  logic [4:0] hdr_rsvd;
  logic [7:0] hdr_target;
  logic [2:0] hdr_thread;
  assign hdr_rsvd   = in_data[31:27];
  assign hdr_target = in_data[26:19];
  assign hdr_thread = in_data[18:16];

  assign xfer = in_valid & in_ready;

  function automatic logic [63:0] mk_word(logic [1:0] kind, logic [7:0] tgt, logic [2:0] thr,
                                          logic [7:0] addr, logic [31:0] data);
    return {1'b1, kind, tgt, thr, addr, 10'd0, data};
  endfunction

  // Header legality check
  always_comb begin
`ifdef CONF_WRITER_BROADCAST_EN
    bad_target = (32'(hdr_target) >= NUM_TARGETS) && (hdr_target != 8'hFF);
`else
    bad_target = (32'(hdr_target) >= NUM_TARGETS);
`endif
    bad_hdr = bad_target || (32'(hdr_thread) >= NUM_THREADS) || (hdr_rsvd != 5'd0);
  end

  // Next-state logic and bus word formation; the bus defaults to idle every cycle
  always_comb begin
    state_d   = state_q;
    target_d  = target_q;
    thread_d  = thread_q;
    loop_pc_d = loop_pc_q;
    cnt_d     = cnt_q;
    idx_d     = idx_q;
    err_d     = err_q;
    bus_d     = 64'd0;
    done_d    = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (xfer) begin
          target_d  = hdr_target;
          thread_d  = hdr_thread;
          loop_pc_d = in_data[15:8];
          cnt_d     = in_data[7:0];
          idx_d     = 8'd0;
          err_d     = bad_hdr;
          state_d   = StData;
        end
      end
      StData: begin
        if (xfer) begin
          // Bad packets are still drained word by word, but nothing reaches the bus
          if (!err_q) bus_d = mk_word(KindMem, target_q, thread_q, idx_q, in_data);
          if (idx_q == cnt_q) begin
            state_d = err_q ? StIdle : StPcMax;
          end else begin
            idx_d = idx_q + 8'd1;
          end
        end
      end
      StPcMax: begin
        bus_d   = mk_word(KindPcMax, target_q, thread_q, 8'd0, {24'd0, cnt_q});
        state_d = StPcLoop;
      end
      StPcLoop: begin
        bus_d   = mk_word(KindPcLoop, target_q, thread_q, 8'd0, {24'd0, loop_pc_q});
        done_d  = 1'b1;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // State and output registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= StIdle;
      target_q  <= 8'd0;
      thread_q  <= 3'd0;
      loop_pc_q <= 8'd0;
      cnt_q     <= 8'd0;
      idx_q     <= 8'd0;
      err_q     <= 1'b0;
      bus_q     <= 64'd0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      target_q  <= target_d;
      thread_q  <= thread_d;
      loop_pc_q <= loop_pc_d;
      cnt_q     <= cnt_d;
      idx_q     <= idx_d;
      err_q     <= err_d;
      bus_q     <= bus_d;
      done_q    <= done_d;
    end
  end

  assign in_ready     = (state_q == StIdle) || (state_q == StData);
  assign busy         = (state_q != StIdle);
  assign err          = err_q;
  assign conf_bus_out = bus_q;
  assign pkt_done     = done_q;

endmodule

// File: tb/tb_conf_bus_writer.sv
// Self-checking bench for conf_bus_writer: directed packets plus randomized
// packets, compared against a schedule of expected bus words built from the
// packet rules and cycle timing.
module tb_conf_bus_writer;

  localparam int unsigned NT  = 128;
  localparam int unsigned NTH = 7;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] in_data = 32'd0;
  logic [63:0] conf_bus_out;
  logic        busy;
  logic        err;
  logic        pkt_done;

  int cyc = 0;
  int n_cmp = 0;
  int n_err = 0;
  bit mon_en = 1'b0;

  // Expected bus contents keyed by cycle; absent means idle bus
  logic [63:0] exp_bus [int];
  bit          exp_done [int];

  conf_bus_writer #(
    .NUM_TARGETS(NT),
    .NUM_THREADS(NTH)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_data     (in_data),
    .conf_bus_out(conf_bus_out),
    .busy        (busy),
    .err         (err),
    .pkt_done    (pkt_done)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s @cyc %0d: got %h expected %h", tag, cyc, got, exp);
    end
  endtask

  function automatic logic [63:0] bus_word(input logic [1:0] kind, input logic [7:0] tgt,
                                           input logic [2:0] thr, input logic [7:0] addr,
                                           input logic [31:0] data);
    return {1'b1, kind, tgt, thr, addr, 10'd0, data};
  endfunction

  // Bus and pkt_done checked every cycle away from the active edge
  always @(negedge clk) begin
    if (mon_en) begin
      check_eq("bus", conf_bus_out, exp_bus.exists(cyc) ? exp_bus[cyc] : 64'd0);
      check_eq("pkt_done", 64'(pkt_done), exp_done.exists(cyc) ? 64'd1 : 64'd0);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_word(input logic [31:0] w);
    in_valid = 1'b1;
    in_data  = w;
    check_eq("in_ready_xfer", 64'(in_ready), 64'd1);
    tick();
    in_valid = 1'b0;
  endtask

  task automatic do_reset();
    exp_bus.delete();
    exp_done.delete();
    in_valid = 1'b0;
    rst = 1'b1;
    #1;
    check_eq("rst_bus", conf_bus_out, 64'd0);
    check_eq("rst_done", 64'(pkt_done), 64'd0);
    check_eq("rst_busy", 64'(busy), 64'd0);
    check_eq("rst_err", 64'(err), 64'd0);
    repeat (2) tick();
    rst = 1'b0;
    #1;
    check_eq("rst_rdy", 64'(in_ready), 64'd1);
  endtask

  // gap < 0: random 0..2 idle cycles before each data word
  task automatic send_pkt(input logic [4:0] res, input logic [7:0] tgt, input logic [2:0] thr,
                          input logic [7:0] lpc, input logic [7:0] cnt, input int gap);
    bit          bad;
    bit          bad_tgt;
    logic [31:0] d;
    int          g;
    bad_tgt = (tgt >= NT);
`ifdef CONF_WRITER_BROADCAST_EN
    if (tgt == 8'hFF) bad_tgt = 1'b0;
`endif
    bad = bad_tgt || (thr >= NTH) || (res != 5'd0);
    push_word({res, tgt, thr, lpc, cnt});
    check_eq("hdr_err", 64'(err), 64'(bad));
    check_eq("hdr_busy", 64'(busy), 64'd1);
    for (int i = 0; i <= int'(cnt); i++) begin
      g = (gap < 0) ? int'($urandom_range(0, 2)) : gap;
      repeat (g) begin
        in_data = $urandom;
        check_eq("gap_rdy", 64'(in_ready), 64'd1);
        check_eq("gap_busy", 64'(busy), 64'd1);
        tick();
      end
      d = $urandom;
      if (!bad) exp_bus[cyc + 1] = bus_word(2'b00, tgt, thr, 8'(i), d);
      push_word(d);
    end
    if (!bad) begin
      exp_bus[cyc + 1]  = bus_word(2'b01, tgt, thr, 8'd0, {24'd0, cnt});
      exp_bus[cyc + 2]  = bus_word(2'b10, tgt, thr, 8'd0, {24'd0, lpc});
      exp_done[cyc + 2] = 1'b1;
      // in_valid toggled here: readiness must not depend on it
      repeat (2) begin
        in_valid = 1'($urandom_range(0, 1));
        in_data  = $urandom;
        check_eq("pc_rdy", 64'(in_ready), 64'd0);
        check_eq("pc_busy", 64'(busy), 64'd1);
        tick();
      end
      in_valid = 1'b0;
      check_eq("end_rdy", 64'(in_ready), 64'd1);
      check_eq("end_busy", 64'(busy), 64'd0);
      check_eq("end_err", 64'(err), 64'd0);
    end else begin
      check_eq("bad_busy", 64'(busy), 64'd0);
      check_eq("bad_err", 64'(err), 64'd1);
    end
  endtask

  initial begin
    logic [31:0] d;
    #2;
    do_reset();
    mon_en = 1'b1;

    // Basic 3-word packet, back to back
    send_pkt(5'd0, 8'd5, 3'd2, 8'd0, 8'd2, 0);
    // Single word with 2-cycle gap
    send_pkt(5'd0, 8'd17, 3'd0, 8'd3, 8'd0, 2);
    // Illegal thread: drained silently, err sticky
    send_pkt(5'd0, 8'd4, 3'd7, 8'd9, 8'd3, 0);
    // Next legal header clears err
    send_pkt(5'd0, 8'd127, 3'd6, 8'd1, 8'd1, -1);
    // Reserved bits set
    send_pkt(5'd4, 8'd1, 3'd1, 8'd2, 8'd1, 0);
    // Broadcast target
    send_pkt(5'd0, 8'hFF, 3'd3, 8'd4, 8'd0, 0);
    // Out-of-range target
    send_pkt(5'd0, 8'd128, 3'd0, 8'd0, 8'd0, 0);
    // Maximum-length packet
    send_pkt(5'd0, 8'd42, 3'd5, 8'd200, 8'd255, 0);

    // Reset after 2nd data word of a cnt=3 packet
    push_word({5'd0, 8'd9, 3'd1, 8'd7, 8'd3});
    for (int i = 0; i < 2; i++) begin
      d = $urandom;
      exp_bus[cyc + 1] = bus_word(2'b00, 8'd9, 3'd1, 8'(i), d);
      push_word(d);
    end
    do_reset();
    repeat (4) begin
      check_eq("post_rst_busy", 64'(busy), 64'd0);
      tick();
    end
    send_pkt(5'd0, 8'd9, 3'd1, 8'd7, 8'd3, 0);

    // Randomized packets
    for (int p = 0; p < 30; p++) begin
      send_pkt(($urandom_range(0, 7) == 0) ? 5'($urandom_range(1, 31)) : 5'd0,
               ($urandom_range(0, 9) == 0) ? 8'hFF : 8'($urandom_range(0, 135)),
               3'($urandom_range(0, 7)), 8'($urandom), 8'($urandom_range(0, 15)), -1);
      repeat ($urandom_range(0, 2)) tick();
    end

    repeat (3) tick();
    mon_en = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/conf_bus_writer.md
# conf_bus_writer

Configuration bus transmitter for the CGRA. Accepts a host-side stream of 32-bit packet words, one header followed by N switch/PE configuration words, and drives the 64-bit `conf_bus` that every per-switch configuration reader snoops. For each packet it emits, in order:

- N memory-write words,
- one pc_max word,
- one pc_loop word.

It sits between the host/DMA configuration port and the CGRA configuration bus.

## Interface
Parameters:
- NUM_TARGETS, 128, number of addressable switches/PEs; valid targets are 0..NUM_TARGETS-1 (max 255)
- NUM_THREADS, 7, number of hardware threads; valid thread ids are 0..NUM_THREADS-1 (max 8)

Ports:
- clk  in  1  clock
- rst  in  1  reset; asynchronous, active-high
- in_valid  in  1  host word valid
- in_ready  out  1  block can accept a word this cycle
- in_data  in  32  host word (header or data)
- conf_bus_out  out  64  configuration bus word, registered
- busy  out  1  high in any state other than IDLE
- err  out  1  sticky error for the current packet
- pkt_done  out  1  one-cycle pulse when a packet's pc_loop word is on the bus

## Operation
- A word transfers on a cycle where in_valid & in_ready.
- Header fields:
  - [31:27] reserved, must be 0
  - [26:19] target
  - [18:16] thread
  - [15:8] loop_pc
  - [7:0] cnt = N-1, so N ranges 1..256
- Bus word fields:
  - [63] valid
  - [62:61] kind: 00 mem write, 01 pc_max, 10 pc_loop, 11 never emitted
  - [60:53] target
  - [52:50] thread
  - [49:42] addr
  - [41:32] 0
  - [31:0] data
- FSM states:
  - IDLE: in_ready=1. On header transfer, latch target/thread/loop_pc/cnt, clear idx. Compute bad = (target>=NUM_TARGETS) | (thread>=NUM_THREADS) | (reserved!=0), and set err=bad. Go to DATA.
  - DATA: in_ready=1. On each transfer:
    - If !err, emit a mem word: addr=idx, data=in_data.
    - If idx==cnt: go to PCMAX when !err, or to IDLE when err. Otherwise idx++.
  - PCMAX: in_ready=0. Emit kind 01, data={24'b0,cnt}, addr=0. Go to PCLOOP.
  - PCLOOP: in_ready=0. Emit kind 10, data={24'b0,loop_pc}, addr=0. Go to IDLE.
- No emission in a cycle means conf_bus_out = 64'b0 on the next cycle. There is never a stale valid.
- idx is 8 bits. With cnt=255 the last address is 255, and no wrap occurs within a packet.
- The bus has no backpressure. The block never stalls once a word is accepted. An in_valid gap in DATA yields bus idle cycles.
- err is cleared only by the next header transfer or by reset. pkt_done never pulses for an err packet.

## Timing
- Reset values: conf_bus_out=0, busy=0, err=0, pkt_done=0. State is IDLE, so in_ready=1 as soon as reset deasserts.
- Reset asserted mid-packet: the FSM returns to IDLE and the bus is 0 from the asserting edge. The partial packet is discarded and no pc words are sent.
- Header accepted at cycle H: no bus word at H+1. busy=1 and err are valid from H+1.
- Data word accepted at cycle c: mem word on the bus at c+1.
- Last data word accepted at L:
  - mem word at L+1, pc_max at L+2, pc_loop at L+3.
  - pkt_done=1 at L+3.
  - in_ready=0 during L+1..L+2, and 1 again at L+3.
  - A new header may be accepted at L+3.
- in_ready is a combinational function of the state only. It is independent of in_valid.

## Configuration
- CONF_WRITER_BROADCAST_EN defined:
  - target 8'hFF is a legal broadcast target regardless of NUM_TARGETS.
  - Words are emitted with target field 8'hFF.
- Not defined: target 8'hFF follows the normal range check. With NUM_TARGETS<=255 it sets err.

## Test plan
- Reset, then header {target=5, thread=2, loop_pc=0, cnt=2}, then data A,B,C back-to-back: bus shows mem words addr 0,1,2 with data A,B,C; then pc_max data=2; then pc_loop data=0. pkt_done fires with pc_loop. Total 6 cycles from header to pkt_done.
- Single-word packet (cnt=0, loop_pc=3) with in_valid gaps of 2 cycles between header and data: idle bus during the gaps; then mem addr 0, pc_max 0, pc_loop 3. in_ready is low exactly 2 cycles.
- Header with thread=7, then cnt+1=4 data words: all 4 consumed, bus stays 0, err=1, no pkt_done. The next valid header clears err.
- Header with target=8'hFF and cnt=0, run once with and once without the macro: broadcast words carry target field 8'hFF, versus err=1 with no bus output.
- cnt=255 packet: 256 mem words with addr 0..255 in order, then pc_max data=255.
- Assert rst after the 2nd data word of a cnt=3 packet: bus 0 immediately, no pc words. After release, a fresh packet runs normally.
